// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: opcodes, FSM states
// and the opcode-to-ALU-control decode.
package alu_nibble_sequencer_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_NOTB  = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_INCA  = 3'd5;
    localparam logic [2:0] OP_NEGA  = 3'd6;
    localparam logic [2:0] OP_PASSA = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic inva;
        logic ena;
        logic enb;
        logic f1;
        logic f0;
        logic cin0;
        logic is_arith;
    } ctrl_t;

    // Field order: inva, ena, enb, f1, f0, first-pass cin, is_arith
    function automatic ctrl_t op_ctrl(input logic [2:0] op);
        ctrl_t c;
        case (op)
            OP_AND:   c = 7'b0110000;
            OP_OR:    c = 7'b0110100;
            OP_NOTB:  c = 7'b0111000;
            OP_ADD:   c = 7'b0111101;
            OP_SUB:   c = 7'b1111111;
            OP_INCA:  c = 7'b0101111;
            OP_NEGA:  c = 7'b1101111;
            OP_PASSA: c = 7'b0101101;
            default:  c = 7'b0000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Drives an external NIB_W-bit ALU slice one nibble per cycle, LSB first,
// with a registered carry chain, and returns the assembled wide result.
module alu_nibble_sequencer
    import alu_nibble_sequencer_pkg::*;
#(
    parameter int  NIB_W  = 4,
    parameter int  N_PASS = 2,
    localparam int DATA_W = NIB_W * N_PASS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_op_i,
    input  logic [DATA_W-1:0] req_a_i,
    input  logic [DATA_W-1:0] req_b_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_cout_o,
    output logic              rsp_zero_o,
    output logic [NIB_W-1:0]  alu_a_o,
    output logic [NIB_W-1:0]  alu_b_o,
    output logic              alu_inva_o,
    output logic              alu_ena_o,
    output logic              alu_enb_o,
    output logic              alu_f0_o,
    output logic              alu_f1_o,
    output logic              alu_cin_o,
    input  logic [NIB_W-1:0]  alu_result_i,
    input  logic              alu_cout_i
);

    localparam int               CNT_W    = (N_PASS > 1) ? $clog2(N_PASS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PASS - 1);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;

    ctrl_t             ctrl_s;
    logic              run_s;

    // In IDLE the decode looks at the incoming opcode (for the first-pass
    // carry); otherwise it decodes the latched one.
    assign ctrl_s = op_ctrl((state_q == ST_IDLE) ? req_op_i : op_q);
    assign run_s  = (state_q == ST_RUN);

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    // Next-state logic: accept, per-nibble pass, response hold
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    res_d   = '0;
                    cnt_d   = '0;
                    carry_d = ctrl_s.cin0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d[cnt_q*NIB_W +: NIB_W] = alu_result_i;
                carry_d = alu_cout_i;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign rsp_valid_o  = (state_q == ST_DONE);
    assign rsp_result_o = res_q;
    assign rsp_cout_o   = (state_q == ST_DONE) && ctrl_s.is_arith && carry_q;
    assign rsp_zero_o   = (res_q == '0);

    // ALU bus is quiet outside RUN so the slice sees all-zero controls
    assign alu_a_o    = run_s ? a_q[cnt_q*NIB_W +: NIB_W] : '0;
    assign alu_b_o    = run_s ? b_q[cnt_q*NIB_W +: NIB_W] : '0;
    assign alu_inva_o = run_s & ctrl_s.inva;
    assign alu_ena_o  = run_s & ctrl_s.ena;
    assign alu_enb_o  = run_s & ctrl_s.enb;
    assign alu_f0_o   = run_s & ctrl_s.f0;
    assign alu_f1_o   = run_s & ctrl_s.f1;
    assign alu_cin_o  = run_s & carry_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with a behavioural 4-bit ALU slice
// attached to its ALU port.
module tb_alu_nibble_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a, req_b;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_cout, rsp_zero;
    logic [3:0] alu_a, alu_b, alu_result;
    logic       alu_inva, alu_ena, alu_enb, alu_f0, alu_f1, alu_cin, alu_cout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.NIB_W(4), .N_PASS(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
        .rsp_cout_o(rsp_cout), .rsp_zero_o(rsp_zero),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_inva_o(alu_inva), .alu_ena_o(alu_ena),
        .alu_enb_o(alu_enb), .alu_f0_o(alu_f0), .alu_f1_o(alu_f1), .alu_cin_o(alu_cin),
        .alu_result_i(alu_result), .alu_cout_i(alu_cout)
    );

    // Behavioural ALU slice: {f1,f0} = 00 AND, 01 OR, 10 NOT B, 11 SUM
    always_comb begin
        logic [3:0] ea, eb;
        logic [4:0] sum;
        ea  = alu_ena ? alu_a : 4'h0;
        ea  = alu_inva ? ~ea : ea;
        eb  = alu_enb ? alu_b : 4'h0;
        sum = {1'b0, ea} + {1'b0, eb} + {4'h0, alu_cin};
        alu_cout = 1'b0;
        case ({alu_f1, alu_f0})
            2'b00:   alu_result = ea & eb;
            2'b01:   alu_result = ea | eb;
            2'b10:   alu_result = ~eb;
            default: begin alu_result = sum[3:0]; alu_cout = sum[4]; end
        endcase
    end

    function automatic logic [9:0] alu_bus();
        return {alu_a, alu_b, alu_inva, alu_ena, alu_enb, alu_f0, alu_f1, alu_cin} == 14'h0 ? 10'h0 : 10'h3FF;
    endfunction

    // Issues a request from IDLE, waits (bounded) for rsp_valid; leaves DUT in DONE.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = 8'h00; req_b = 8'h00; req_op = 3'd0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin lat = k; break; end
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 3'd0; req_a = 8'h00; req_b = 8'h00;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        n_checks++; if (req_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_checks++; if (rsp_result !== 8'h00) begin n_fail++; $display("FAIL reset_result got=%h exp=00", rsp_result); end
        n_checks++; if (rsp_cout !== 1'b0)   begin n_fail++; $display("FAIL reset_cout got=%b exp=0", rsp_cout); end
        n_checks++; if (rsp_zero !== 1'b1)   begin n_fail++; $display("FAIL reset_zero got=%b exp=1", rsp_zero); end
        n_checks++; if (alu_bus() !== 10'h0) begin n_fail++; $display("FAIL reset_alu_idle got=%h exp=0", alu_bus()); end
    endtask

    task automatic test_add();
        req_op = 3'd3; req_a = 8'h3C; req_b = 8'h4F; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = 8'hFF; req_b = 8'hFF;
        n_checks++; if ({alu_a, alu_b, alu_cin} !== {4'hC, 4'hF, 1'b0}) begin n_fail++; $display("FAIL add_pass0 got a=%h b=%h cin=%b exp a=c b=f cin=0", alu_a, alu_b, alu_cin); end
        n_checks++; if ({alu_inva, alu_ena, alu_enb, alu_f1, alu_f0} !== 5'b01111) begin n_fail++; $display("FAIL add_ctrl got=%b exp=01111", {alu_inva, alu_ena, alu_enb, alu_f1, alu_f0}); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL add_req_ready_run got=%b exp=0", req_ready); end
        @(posedge clk); #1;
        n_checks++; if ({alu_a, alu_b, alu_cin} !== {4'h3, 4'h4, 1'b1}) begin n_fail++; $display("FAIL add_pass1 got a=%h b=%h cin=%b exp a=3 b=4 cin=1", alu_a, alu_b, alu_cin); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_valid_early got=%b exp=0", rsp_valid); end
        @(posedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid_lat2 got=%b exp=1", rsp_valid); end
        n_checks++; if ({rsp_result, rsp_cout, rsp_zero} !== {8'h8B, 1'b0, 1'b0}) begin n_fail++; $display("FAIL add_result got=%h/%b/%b exp=8b/0/0", rsp_result, rsp_cout, rsp_zero); end
        n_checks++; if (alu_bus() !== 10'h0) begin n_fail++; $display("FAIL add_alu_done got=%h exp=0", alu_bus()); end
        release_rsp();
        n_checks++; if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL add_back_idle got=%b exp=10", {req_ready, rsp_valid}); end
    endtask

    task automatic test_sub();
        int lat;
        run_op(3'd4, 8'h05, 8'h05, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sub_eq_latency got=%0d exp=2", lat); end
        n_checks++; if ({rsp_result, rsp_cout, rsp_zero} !== {8'h00, 1'b1, 1'b1}) begin n_fail++; $display("FAIL sub_eq got=%h/%b/%b exp=00/1/1", rsp_result, rsp_cout, rsp_zero); end
        release_rsp();
        run_op(3'd4, 8'h01, 8'h00, lat);
        n_checks++; if ({rsp_result, rsp_cout, rsp_zero} !== {8'hFF, 1'b0, 1'b0}) begin n_fail++; $display("FAIL sub_borrow got=%h/%b/%b exp=ff/0/0", rsp_result, rsp_cout, rsp_zero); end
        release_rsp();
    endtask

    task automatic test_inc_neg();
        int lat;
        run_op(3'd5, 8'hFF, 8'h12, lat);
        n_checks++; if ({rsp_result, rsp_cout, rsp_zero} !== {8'h00, 1'b1, 1'b1}) begin n_fail++; $display("FAIL inca_wrap got=%h/%b/%b exp=00/1/1", rsp_result, rsp_cout, rsp_zero); end
        release_rsp();
        run_op(3'd6, 8'h01, 8'h77, lat);
        n_checks++; if ({rsp_result, rsp_cout, rsp_zero} !== {8'hFF, 1'b0, 1'b0}) begin n_fail++; $display("FAIL nega got=%h/%b/%b exp=ff/0/0", rsp_result, rsp_cout, rsp_zero); end
        release_rsp();
        run_op(3'd7, 8'hA7, 8'hFF, lat);
        n_checks++; if ({rsp_result, rsp_cout} !== {8'hA7, 1'b0}) begin n_fail++; $display("FAIL passa got=%h/%b exp=a7/0", rsp_result, rsp_cout); end
        release_rsp();
    endtask

    task automatic test_logic();
        int lat;
        run_op(3'd0, 8'hF0, 8'h3C, lat);
        n_checks++; if ({rsp_result, rsp_cout} !== {8'h30, 1'b0}) begin n_fail++; $display("FAIL and got=%h/%b exp=30/0", rsp_result, rsp_cout); end
        release_rsp();
        run_op(3'd2, 8'h00, 8'hA5, lat);
        n_checks++; if ({rsp_result, rsp_cout} !== {8'h5A, 1'b0}) begin n_fail++; $display("FAIL notb got=%h/%b exp=5a/0", rsp_result, rsp_cout); end
        release_rsp();
        run_op(3'd1, 8'h0F, 8'hA0, lat);
        n_checks++; if ({rsp_result, rsp_zero} !== {8'hAF, 1'b0}) begin n_fail++; $display("FAIL or got=%h/%b exp=af/0", rsp_result, rsp_zero); end
        release_rsp();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(3'd3, 8'h12, 8'h34, lat);
        req_op = 3'd0; req_a = 8'h00; req_b = 8'h00; req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_checks++; if ({rsp_valid, req_ready, rsp_result} !== {1'b1, 1'b0, 8'h46}) begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%h exp=1/0/46", k, rsp_valid, req_ready, rsp_result); end
        end
        req_valid = 1'b0;
        release_rsp();
        n_checks++; if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_release got=%b exp=10", {req_ready, rsp_valid}); end
        run_op(3'd3, 8'hFF, 8'h01, lat);
        n_checks++; if ({rsp_result, rsp_cout, rsp_zero} !== {8'h00, 1'b1, 1'b1}) begin n_fail++; $display("FAIL bp_next got=%h/%b/%b exp=00/1/1", rsp_result, rsp_cout, rsp_zero); end
        release_rsp();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        req_op = 3'd3; req_a = 8'h3C; req_b = 8'h4F; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if ({req_ready, rsp_valid, rsp_result, rsp_zero} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin n_fail++; $display("FAIL rst_mid got=%b/%b/%h/%b exp=1/0/00/1", req_ready, rsp_valid, rsp_result, rsp_zero); end
        n_checks++; if (alu_bus() !== 10'h0) begin n_fail++; $display("FAIL rst_mid_alu got=%h exp=0", alu_bus()); end
        run_op(3'd3, 8'h01, 8'h01, lat);
        n_checks++; if ({rsp_result, rsp_cout, lat} !== {8'h02, 1'b0, 32'd2}) begin n_fail++; $display("FAIL rst_after_add got=%h/%b lat=%0d exp=02/0 lat=2", rsp_result, rsp_cout, lat); end
        release_rsp();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_inc_neg();
        test_logic();
        test_backpressure();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
